// File: rtl/avalon_pkg.sv
// Shared types and constants for the Avalon-MM initiator used by the MIPS core.
package avalon_pkg;

    // Default widths and timeout depth.
    localparam int AVM_ADDR_W_DEF  = 32;
    localparam int AVM_DATA_W_DEF  = 32;
    localparam int AVM_TIMEOUT_DEF = 64;

    // Clears the byte offset so the bus only sees word addresses.
    localparam logic [31:0] AVM_WORD_MASK = 32'hFFFF_FFFC;

    // Initiator states: waiting for a core request, driving a strobe,
    // and the fixed-latency read data cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RDATA = 2'd2
    } avm_state_t;

endpackage

// File: rtl/avm_wait_timer.sv
// Counts consecutive waitrequest cycles of one bus access and flags the cycle
// on which the stall limit is reached. Only built when AVM_TIMEOUT_EN is defined.
module avm_wait_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,    // high whenever no access is on the bus
    input  logic stall_i,    // bus access stalled by waitrequest this cycle
    output logic expired_o   // this stall cycle is the TIMEOUT_CYCLES-th one
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: held at zero outside an access, bumped on each stall cycle.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (stall_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = stall_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/avalon_master_if.sv
// Avalon-MM initiator for the MIPS core: takes one word access at a time from
// the core, drives the bus honouring waitrequest, and returns a single-cycle
// response. All bus outputs and responses are registered.
// Optional feature: define AVM_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES consecutive waitrequest cycles (reported via resp_err).
module avalon_master_if
    import avalon_pkg::*;
#(
    parameter int ADDR_W         = AVM_ADDR_W_DEF,
    parameter int DATA_W         = AVM_DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = AVM_TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    // Core request side
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_byteen,
    // Core response side
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    // Avalon-MM bus
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    input  logic                waitrequest,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   readdata
);

    localparam int BE_W = DATA_W / 8;

    // Word mask at the configured address width.
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(~AVM_WORD_MASK);

    avm_state_t        state_q, state_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic [BE_W-1:0]   byteenable_q, byteenable_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              timeout_hit;

`ifdef AVM_TIMEOUT_EN
    logic resp_err_q;

    avm_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q != BUS),
        .stall_i   ((state_q == BUS) && waitrequest),
        .expired_o (timeout_hit)
    );

    // Error flag pulses together with the aborting response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_err_q <= 1'b0;
        end else begin
            resp_err_q <= timeout_hit;
        end
    end

    assign resp_err = resp_err_q;
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign resp_err           = 1'b0;
`endif

    // Next-state and next-output decode for the access FSM.
    always_comb begin
        // NOTE: every _d starts as its _q (pulses start at 0) so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_d      = state_q;
        read_d       = read_q;
        write_d      = write_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    address_d    = req_addr & ADDR_MASK;
                    writedata_d  = req_wdata;
                    byteenable_d = req_byteen;
                    write_d      = req_write;
                    read_d       = !req_write;
                    state_d      = BUS;
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (write_q) begin
                        resp_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        state_d = RDATA;
                    end
                end else if (timeout_hit) begin
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            RDATA: begin
                resp_rdata_d = readdata;
                resp_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered bus/response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= '0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the
            // pre-edge values and they all change together.
            state_q      <= state_d;
            read_q       <= read_d;
            write_q      <= write_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign read       = read_q;
    assign write      = write_q;
    assign address    = address_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

endmodule
